// File: rtl/pt_fifo_pkg.sv
// Shared sizing and pointer-wrap helpers for the PtRing queue family.
// Pure functions and types only; no logic state lives here.
package pt_fifo_pkg;

    typedef int unsigned pt_idx_t;

    // Occupancy counter width: must hold values 0..depth inclusive.
    function automatic int pt_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int pt_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Wrap by explicit compare so non-power-of-2 depths step DEPTH-1 -> 0.
    function automatic pt_idx_t pt_wrap_inc(input pt_idx_t idx, input pt_idx_t depth);
        return (idx == depth - 1) ? pt_idx_t'(0) : idx + 1;
    endfunction

endpackage

// File: rtl/pt_reg_fifo_if.sv
// Write/read request and status bundle between a PtRing queue and its user.
// master drives requests and write data; slave is the FIFO itself.
interface pt_reg_fifo_if
    import pt_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = pt_cnt_w(DEPTH);

    logic             iWrEn;
    logic [WIDTH-1:0] iWrDat;
    logic             iRdEn;
    logic             oFul;
    logic             oAlmFul;
    logic             oEmpty;
    logic [CW-1:0]    oCnt;
    logic [DEPTH-1:0] oDatVld;
    logic [WIDTH-1:0] oRdDat;
    logic             oOvf;
    logic             oUdf;

    modport master (
        output iWrEn, iWrDat, iRdEn,
        input  oFul, oAlmFul, oEmpty, oCnt, oDatVld, oRdDat, oOvf, oUdf
    );

    modport slave (
        input  iWrEn, iWrDat, iRdEn,
        output oFul, oAlmFul, oEmpty, oCnt, oDatVld, oRdDat, oOvf, oUdf
    );

endinterface

// File: rtl/pt_fifo_ptr.sv
// Registered wrapping index 0..DEPTH-1, advanced by one on iInc.
// Latency: new value visible the cycle after iInc; no backpressure (caller gates iInc).
module pt_fifo_ptr
    import pt_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = pt_ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iInc,
    output logic [PW-1:0] oPtr
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (iInc) begin
            ptr_d = PW'(pt_wrap_inc(pt_idx_t'(ptr_q), pt_idx_t'(DEPTH)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign oPtr = ptr_q;

endmodule

// File: rtl/pt_reg_fifo.sv
// First-word-fall-through register FIFO with occupancy, almost-full and per-slot valid mask.
// Latency 1 write->head, no bypass; writes dropped when full, reads dropped when empty (PT_FIFO_ERR_CHK_EN adds sticky oOvf/oUdf).
module pt_reg_fifo
    import pt_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 1
) (
    input  logic         clk,
    input  logic         rst,
    pt_reg_fifo_if.slave bus
);

    localparam int CW    = pt_cnt_w(DEPTH);
    localparam int PW    = pt_ptr_w(DEPTH);
    localparam int AF_TH = DEPTH - AF_MARGIN;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             wr_acc;
    logic             rd_acc;
    logic [DEPTH-1:0] dat_vld;

    assign full   = (cnt_q == CW'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign wr_acc = bus.iWrEn & ~full;
    assign rd_acc = bus.iRdEn & ~empty;

    pt_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk  (clk),
        .rst  (rst),
        .iInc (wr_acc),
        .oPtr (wr_ptr)
    );

    pt_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk  (clk),
        .rst  (rst),
        .iInc (rd_acc),
        .oPtr (rd_ptr)
    );

    // Storage is cleared on reset so the head reads as zero until the first write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_acc) begin
            mem_q[wr_ptr] <= bus.iWrDat;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        dat_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            dat_vld[i] = (CW'(i) < cnt_q);
        end
    end

    assign bus.oFul    = full;
    assign bus.oEmpty  = empty;
    assign bus.oAlmFul = (cnt_q >= CW'(AF_TH));
    assign bus.oCnt    = cnt_q;
    assign bus.oDatVld = dat_vld;
    assign bus.oRdDat  = mem_q[rd_ptr];

`ifdef PT_FIFO_ERR_CHK_EN
    logic ovf_q;
    logic udf_q;

    // Flags record attempted requests, not accepted ones; they hold until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.iWrEn & full) begin
                ovf_q <= 1'b1;
            end
            if (bus.iRdEn & empty) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign bus.oOvf = ovf_q;
    assign bus.oUdf = udf_q;

`ifndef SYNTHESIS
    ovf_a: assert property (@(posedge clk) disable iff (rst) !(bus.iWrEn && full))
        else $error("pt_reg_fifo: write while full, data dropped");
    udf_a: assert property (@(posedge clk) disable iff (rst) !(bus.iRdEn && empty))
        else $error("pt_reg_fifo: read while empty, request dropped");
`endif
`else
    assign bus.oOvf = 1'b0;
    assign bus.oUdf = 1'b0;
`endif

endmodule

// File: tb/tb_pt_reg_fifo.sv
// Bench for pt_reg_fifo: queue-based reference model checked every cycle, plus directed literal checks.
// Instance A is DEPTH=4/AF_MARGIN=1, instance B is DEPTH=3 for pointer wrap.
module tb_pt_reg_fifo;

`ifdef PT_FIFO_ERR_CHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic clk;
    logic rst;
    bit   run;
    bit   cmp_en;
    int   checks;
    int   errors;

    pt_reg_fifo_if #(.WIDTH(8), .DEPTH(4)) ifa ();
    pt_reg_fifo_if #(.WIDTH(8), .DEPTH(3)) ifb ();

    pt_reg_fifo #(.WIDTH(8), .DEPTH(4), .AF_MARGIN(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    pt_reg_fifo #(.WIDTH(8), .DEPTH(3), .AF_MARGIN(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial begin
        clk = 1'b0;
        wait (run);
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue per instance, updated on accepted requests only.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit ovf_a, udf_a, ovf_b, udf_b;

    always @(posedge clk or posedge rst) begin : model_a
        bit w, r;
        if (rst) begin
            qa.delete();
            ovf_a = 1'b0;
            udf_a = 1'b0;
        end else begin
            w = ifa.iWrEn && (qa.size() < 4);
            r = ifa.iRdEn && (qa.size() > 0);
            if (ifa.iWrEn && qa.size() == 4) ovf_a = 1'b1;
            if (ifa.iRdEn && qa.size() == 0) udf_a = 1'b1;
            if (r) void'(qa.pop_front());
            if (w) qa.push_back(ifa.iWrDat);
        end
    end

    always @(posedge clk or posedge rst) begin : model_b
        bit w, r;
        if (rst) begin
            qb.delete();
            ovf_b = 1'b0;
            udf_b = 1'b0;
        end else begin
            w = ifb.iWrEn && (qb.size() < 3);
            r = ifb.iRdEn && (qb.size() > 0);
            if (ifb.iWrEn && qb.size() == 3) ovf_b = 1'b1;
            if (ifb.iRdEn && qb.size() == 0) udf_b = 1'b1;
            if (r) void'(qb.pop_front());
            if (w) qb.push_back(ifb.iWrDat);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("a_cnt",    32'(ifa.oCnt),    32'(qa.size()));
            chk("a_empty",  32'(ifa.oEmpty),  32'(qa.size() == 0));
            chk("a_ful",    32'(ifa.oFul),    32'(qa.size() == 4));
            chk("a_almful", 32'(ifa.oAlmFul), 32'(qa.size() >= 3));
            chk("a_datvld", 32'(ifa.oDatVld), (32'd1 << qa.size()) - 32'd1);
            chk("a_ovf",    32'(ifa.oOvf),    32'(ERRCHK & ovf_a));
            chk("a_udf",    32'(ifa.oUdf),    32'(ERRCHK & udf_a));
            if (qa.size() > 0) chk("a_rddat", 32'(ifa.oRdDat), 32'(qa[0]));
            chk("b_cnt",    32'(ifb.oCnt),    32'(qb.size()));
            chk("b_empty",  32'(ifb.oEmpty),  32'(qb.size() == 0));
            chk("b_ful",    32'(ifb.oFul),    32'(qb.size() == 3));
            chk("b_almful", 32'(ifb.oAlmFul), 32'(qb.size() >= 2));
            chk("b_datvld", 32'(ifb.oDatVld), (32'd1 << qb.size()) - 32'd1);
            if (qb.size() > 0) chk("b_rddat", 32'(ifb.oRdDat), 32'(qb[0]));
        end
    end

    task automatic cyc_a(input bit wr, input logic [7:0] dat, input bit rd);
        ifa.iWrEn  = wr;
        ifa.iWrDat = dat;
        ifa.iRdEn  = rd;
        @(posedge clk);
        @(negedge clk);
        ifa.iWrEn = 1'b0;
        ifa.iRdEn = 1'b0;
    endtask

    task automatic cyc_b(input bit wr, input logic [7:0] dat, input bit rd);
        ifb.iWrEn  = wr;
        ifb.iWrDat = dat;
        ifb.iRdEn  = rd;
        @(posedge clk);
        @(negedge clk);
        ifb.iWrEn = 1'b0;
        ifb.iRdEn = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cmp_en     = 1'b0;
        rst        = 1'b0;
        ifa.iWrEn  = 1'b0;
        ifa.iWrDat = '0;
        ifa.iRdEn  = 1'b0;
        ifb.iWrEn  = 1'b0;
        ifb.iWrDat = '0;
        ifb.iRdEn  = 1'b0;

        // Reset with no clock running.
        #1 rst = 1'b1;
        #2;
        chk("rst_empty",  32'(ifa.oEmpty),  32'd1);
        chk("rst_cnt",    32'(ifa.oCnt),    32'd0);
        chk("rst_datvld", 32'(ifa.oDatVld), 32'd0);
        chk("rst_ful",    32'(ifa.oFul),    32'd0);
        chk("rst_almful", 32'(ifa.oAlmFul), 32'd0);
        chk("rst_rddat",  32'(ifa.oRdDat),  32'd0);
        chk("rst_ovf",    32'(ifa.oOvf),    32'd0);
        run = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        cmp_en = 1'b1;
        repeat (5) cyc_a(1'b0, 8'h00, 1'b0);
        chk("idle_empty", 32'(ifa.oEmpty), 32'd1);

        // Fill and overflow.
        for (int i = 1; i <= 4; i++) begin
            cyc_a(1'b1, 8'(i), 1'b0);
            if (i == 2) chk("fill2_almful", 32'(ifa.oAlmFul), 32'd0);
            if (i == 3) begin
                chk("fill3_almful", 32'(ifa.oAlmFul), 32'd1);
                chk("fill3_ful",    32'(ifa.oFul),    32'd0);
            end
        end
        chk("fill4_ful",    32'(ifa.oFul),    32'd1);
        chk("fill4_datvld", 32'(ifa.oDatVld), 32'hf);
        chk("fill4_head",   32'(ifa.oRdDat),  32'h01);
        cyc_a(1'b1, 8'h05, 1'b0);
        chk("ovf_cnt", 32'(ifa.oCnt), 32'd4);
        chk("ovf_flag", 32'(ifa.oOvf), 32'(ERRCHK));

        // Drain and underflow.
        for (int i = 1; i <= 4; i++) begin
            chk("drain_head", 32'(ifa.oRdDat), 32'(i));
            cyc_a(1'b0, 8'h00, 1'b1);
        end
        chk("drain_empty", 32'(ifa.oEmpty), 32'd1);
        cyc_a(1'b0, 8'h00, 1'b1);
        chk("udf_cnt",  32'(ifa.oCnt), 32'd0);
        chk("udf_flag", 32'(ifa.oUdf), 32'(ERRCHK));

        // Simultaneous write+read at full and at empty.
        for (int i = 0; i < 4; i++) cyc_a(1'b1, 8'(8'h11 + i), 1'b0);
        cyc_a(1'b1, 8'h55, 1'b1);
        chk("full_wr_rd_cnt",  32'(ifa.oCnt),   32'd3);
        chk("full_wr_rd_head", 32'(ifa.oRdDat), 32'h12);
        repeat (3) cyc_a(1'b0, 8'h00, 1'b1);
        chk("empty_again", 32'(ifa.oEmpty), 32'd1);
        cyc_a(1'b1, 8'h66, 1'b1);
        chk("empty_wr_rd_cnt",  32'(ifa.oCnt),   32'd1);
        chk("empty_wr_rd_head", 32'(ifa.oRdDat), 32'h66);

        // Asynchronous reset between edges at occupancy 2.
        cyc_a(1'b1, 8'h77, 1'b0);
        chk("pre_rst_cnt", 32'(ifa.oCnt), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cnt",    32'(ifa.oCnt),    32'd0);
        chk("mid_rst_empty",  32'(ifa.oEmpty),  32'd1);
        chk("mid_rst_datvld", 32'(ifa.oDatVld), 32'd0);
        chk("mid_rst_rddat",  32'(ifa.oRdDat),  32'd0);
        chk("mid_rst_udf",    32'(ifa.oUdf),    32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        cyc_a(1'b1, 8'hA5, 1'b0);
        chk("post_rst_head", 32'(ifa.oRdDat), 32'hA5);
        chk("post_rst_cnt",  32'(ifa.oCnt),   32'd1);

        // Wrap on DEPTH=3 at steady occupancy 1.
        cyc_b(1'b1, 8'h20, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("wrap_head", 32'(ifb.oRdDat), 32'(8'h20 + i));
            cyc_b(1'b1, 8'(8'h21 + i), 1'b1);
            chk("wrap_cnt", 32'(ifb.oCnt), 32'd1);
        end
        chk("wrap_last_head", 32'(ifb.oRdDat), 32'h2a);

        repeat (2) cyc_a(1'b0, 8'h00, 1'b0);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
